ysyx_22041412_ifu: RTL and testbench

Instruction fetch unit that feeds the decode stage of the 5-stage core. It owns the fetch PC and issues in-order requests to instruction memory over a valid/ready channel. Memory may answer with variable latency; responses are buffered in a small reorder-free queue and handed to ID through a valid/ready handshake. A redirect from branch/jump resolution flushes the queue and discards stale in-flight responses.

---
 rtl/ysyx_22041412_ifu_if.sv | 22 ++
 rtl/ysyx_22041412_ifu.sv | 72 +++++++
 tb/tb_ysyx_22041412_ifu.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ysyx_22041412_ifu_if.sv
// ysyx_22041412_ifu_if: redirect, instruction-memory and IF/ID handshake signals of the fetch unit
interface ysyx_22041412_ifu_if;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready;
    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst
    );
endinterface

// File: rtl/ysyx_22041412_ifu.sv
// ysyx_22041412_ifu: in-order instruction fetch with a DEPTH-entry response queue and redirect flush
module ysyx_22041412_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          DEPTH    = 4
) (
    input logic                 clk,
    input logic                 rst,
    ysyx_22041412_ifu_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    logic [63:0]    fetch_pc;
    logic [63:0]    pc_q   [DEPTH];
    logic [31:0]    inst_q [DEPTH];
    logic [DEPTH-1:0] filled;
    logic [AW-1:0]  head, tail, fptr;
    logic [AW:0]    occ, unf, drop_cnt;
    logic           fire, fill, drop, pop;
    // occ never exceeds DEPTH, so its top bit alone means full
    assign bus.imem_req_valid = rst & ~occ[AW] & ~bus.redirect_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign fire = bus.imem_req_valid & bus.imem_req_ready;
    assign drop = bus.imem_resp_valid & (drop_cnt != '0);
    assign fill = bus.imem_resp_valid & (drop_cnt == '0) & (unf != '0);
    assign pop  = filled[head] & bus.id_ready;
    assign bus.if_valid = filled[head];
    assign bus.if_pc    = filled[head] ? pc_q[head] : '0;
    assign bus.if_inst  = filled[head] ? inst_q[head] : '0;
    always_ff @(posedge clk) begin
        if (fire) pc_q[tail] <= fetch_pc;
        if (fill) inst_q[fptr] <= bus.imem_resp_data;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            filled   <= '0;
            head     <= '0;
            tail     <= '0;
            fptr     <= '0;
            occ      <= '0;
            unf      <= '0;
            drop_cnt <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_pc & ~64'd3;
            filled   <= '0;
            head     <= '0;
            tail     <= '0;
            fptr     <= '0;
            occ      <= '0;
            unf      <= '0;
            // every unfilled entry still owes a beat; the beat arriving now settles one debt
            drop_cnt <= drop_cnt + unf - (AW+1)'(drop | fill);
        end else begin
            if (fire) begin
                tail     <= tail + 1'b1;
                fetch_pc <= fetch_pc + 64'd4;
            end
            if (drop) drop_cnt <= drop_cnt - 1'b1;
            if (fill) begin
                filled[fptr] <= 1'b1;
                fptr         <= fptr + 1'b1;
            end
            if (pop) begin
                filled[head] <= 1'b0;
                head         <= head + 1'b1;
            end
            occ <= occ + (AW+1)'(fire) - (AW+1)'(pop);
            unf <= unf + (AW+1)'(fire) - (AW+1)'(fill);
        end
    end
    always_ff @(posedge clk)
        if (rst) assert (!(bus.imem_resp_valid && drop_cnt == '0 && unf == '0));
endmodule

// File: tb/tb_ysyx_22041412_ifu.sv
// tb_ysyx_22041412_ifu: directed and random fetch traffic checked against an epoch-tagged queue model
module tb_ysyx_22041412_ifu;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    ysyx_22041412_ifu_if bus();
    ysyx_22041412_ifu #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic [63:0] addr;
        int          due;
        int          ep;
    } mreq_t;
    mreq_t       memq[$];
    logic [63:0] q_pc[$];
    logic [63:0] mpc = RESET_PC;
    int nfill = 0, epoch = 0, cyc = 0, lat = 1, checks = 0, errors = 0;
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9bdf;
    endfunction
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic idle();
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.id_ready        = 1'b0;
    endtask
    // entered just after a falling edge; returns at the next falling edge
    task automatic step(input bit rv, input logic [63:0] rpc, input bit rdy, input bit idr);
        bit beat, fresh, exp_rv, fire, pop;
        mreq_t m;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.imem_req_ready = rdy;
        bus.id_ready       = idr;
        beat  = memq.size() > 0 && memq[0].due <= cyc;
        fresh = 1'b0;
        if (beat) begin
            m = memq.pop_front();
            fresh = (m.ep == epoch);
            bus.imem_resp_data = mem_word(m.addr);
        end else bus.imem_resp_data = $urandom;
        bus.imem_resp_valid = beat;
        #1;
        exp_rv = !rv && q_pc.size() < DEPTH;
        chk("req_valid", 64'(bus.imem_req_valid), 64'(exp_rv));
        chk("req_addr", bus.imem_req_addr, mpc);
        chk("if_valid", 64'(bus.if_valid), 64'(nfill > 0));
        chk("if_pc", bus.if_pc, nfill > 0 ? q_pc[0] : 64'd0);
        chk("if_inst", 64'(bus.if_inst), nfill > 0 ? 64'(mem_word(q_pc[0])) : 64'd0);
        fire = exp_rv && rdy;
        if (rv) begin
            q_pc.delete();
            nfill = 0;
            epoch++;
            mpc = rpc & ~64'd3;
        end else begin
            pop = nfill > 0 && idr;
            if (pop) begin
                q_pc.delete(0);
                nfill--;
            end
            if (fresh) nfill++;
            if (fire) begin
                memq.push_back('{mpc, cyc + lat, epoch});
                q_pc.push_back(mpc);
                mpc += 64'd4;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask
    task automatic do_reset();
        #2 rst = 1'b0;
        idle();
        #1;
        chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("rst_req_addr", bus.imem_req_addr, RESET_PC);
        chk("rst_if_valid", 64'(bus.if_valid), 64'd0);
        chk("rst_if_pc", bus.if_pc, 64'd0);
        chk("rst_if_inst", 64'(bus.if_inst), 64'd0);
        memq.delete();
        q_pc.delete();
        nfill = 0;
        epoch++;
        mpc = RESET_PC;
        @(negedge clk);
        rst = 1'b1;
    endtask
    initial begin
        idle();
        @(negedge clk);
        do_reset();
        lat = 1;
        repeat (12) step(1'b0, '0, 1'b1, 1'b1);
        do_reset();
        repeat (8) step(1'b0, '0, 1'b1, 1'b0);
        chk("t2_full", 64'(bus.imem_req_valid), 64'd0);
        chk("t2_head_pc", bus.if_pc, RESET_PC);
        chk("t2_next_addr", bus.imem_req_addr, 64'h8000_0010);
        repeat (8) step(1'b0, '0, 1'b1, 1'b1);
        do_reset();
        lat = 3;
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 64'h8000_1002, 1'b1, 1'b1);
        chk("t3_redirect_addr", bus.imem_req_addr, 64'h8000_1000);
        repeat (10) step(1'b0, '0, 1'b1, 1'b1);
        do_reset();
        lat = 1;
        repeat (4) step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 64'h8000_2000, 1'b1, 1'b1);
        repeat (8) step(1'b0, '0, 1'b1, 1'b1);
        do_reset();
        repeat (4) step(1'b0, '0, 1'b1, 1'b0);
        chk("t5_pre_valid", 64'(bus.if_valid), 64'd1);
        do_reset();
        chk("t5_restart_addr", bus.imem_req_addr, RESET_PC);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1);
        chk("t6_top_addr", bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("t6_wrap_addr", bus.imem_req_addr, 64'd0);
        repeat (6) step(1'b0, '0, 1'b1, 1'b1);
        for (int s = 0; s < 6; s++) begin
            lat = $urandom_range(1, 3);
            repeat (100)
                step($urandom_range(0, 19) == 0, {$urandom, $urandom}, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 2) != 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
